// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO of {PC, instruction, redirect} between fetch and decode.
// Define FETCHQ_BYPASS_EN to let an entry arriving at an empty queue go straight to decode.
module fetch_queue #(
  parameter int WIDTH  = 31,
  parameter int IWIDTH = 31,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enq_valid,
  input  logic [WIDTH:0]           enq_pc,
  input  logic [IWIDTH:0]          enq_instr,
  input  logic                     enq_redirect,
  input  logic                     flush,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [WIDTH:0]           deq_pc,
  output logic [IWIDTH:0]          deq_instr,
  output logic                     deq_redirect,
  output logic                     freeze,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH:0]  pcMem_q    [DEPTH];
  logic [IWIDTH:0] instrMem_q [DEPTH];
  logic            redirMem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic full, empty, bypass, storeValid, enqFire, deqFire;

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
`ifdef FETCHQ_BYPASS_EN
    bypass     = empty & enq_valid & deq_ready & ~flush;
`else
    bypass     = 1'b0;
`endif
    storeValid = ~empty & ~flush;
    // A full queue drops the enqueue even when decode drains the head; freeze re-presents it.
    enqFire    = enq_valid & ~full & ~flush & ~bypass;
    deqFire    = storeValid & deq_ready;
  end

  always_comb begin
    deq_valid    = storeValid | bypass;
    deq_pc       = pcMem_q[head_q];
    deq_instr    = instrMem_q[head_q];
    deq_redirect = redirMem_q[head_q];
    if (bypass) begin
      deq_pc       = enq_pc;
      deq_instr    = enq_instr;
      deq_redirect = enq_redirect;
    end
    freeze = full;
    count  = count_q;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enqFire) tail_d = tail_q + PTR_W'(1);
      if (deqFire) head_d = head_q + PTR_W'(1);
      case ({enqFire, deqFire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcMem_q[i]    <= '0;
        instrMem_q[i] <= '0;
        redirMem_q[i] <= 1'b0;
      end
    end else if (enqFire) begin
      pcMem_q[tail_q]    <= enq_pc;
      instrMem_q[tail_q] <= enq_instr;
      redirMem_q[tail_q] <= enq_redirect;
    end
  end

endmodule
